// File: rtl/jk_pkg.sv
// Shared definitions for the JK mode counter: operation encodings and a
// per-bit JK next-state helper used by both the counter and its cells.
package jk_pkg;

  // Operation select encodings driven on the counter's mode input.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_JK   = 2'b11;

  // Classic JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_next_bit(input logic j_in, input logic k_in, input logic q_in);
    logic r;
    case ({j_in, k_in})
      2'b00:   r = q_in;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q_in;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next state from the JK characteristic equation.
  always_comb begin
    q_d = jk_next_bit(j, k, q_q);
  end

  // State register; reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mode_counter.sv
// Multi-mode counter built from JK cells: hold, up, down (both wrapping at
// MAX_COUNT) and a direct per-bit JK mode. Clear, preset and clamped parallel
// load override counting. Optional macro JK_MODE_COUNTER_WRAP_EN adds a
// registered one-cycle wrap pulse output.
module jk_mode_counter
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
`ifdef JK_MODE_COUNTER_WRAP_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] next_d;
  logic [WIDTH-1:0] up_d;
  logic [WIDTH-1:0] down_d;
  logic [WIDTH-1:0] jk_d;
  logic [WIDTH-1:0] load_d;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             at_max;
  logic             at_zero;
  logic             count_active;

  // Wrap boundaries; ">=" on the up side lets a JK-mode value above the
  // modulus fall back to zero on the next up count.
  assign at_max  = (state_q >= MAX_VAL);
  assign at_zero = (state_q == '0);

  // Candidate next values for each counting operation.
  always_comb begin
    up_d   = at_max  ? '0      : state_q + WIDTH'(1);
    down_d = at_zero ? MAX_VAL : state_q - WIDTH'(1);
    load_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  end

  // Direct JK mode evaluates each bit with its own J/K pair; no modulus.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_next
      assign jk_d[gi] = jk_next_bit(j[gi], k[gi], state_q[gi]);
    end
  endgenerate

  // Counting only takes effect when no override input is asserted.
  assign count_active = en && !clear && !preset && !load;

  // Priority select of the next value; reset is applied inside the cells.
  always_comb begin
    next_d = state_q;
    if (clear) begin
      next_d = '0;
    end else if (preset) begin
      next_d = MAX_VAL;
    end else if (load) begin
      next_d = load_d;
    end else if (en) begin
      case (mode)
        MODE_HOLD: next_d = state_q;
        MODE_UP:   next_d = up_d;
        MODE_DOWN: next_d = down_d;
        MODE_JK:   next_d = jk_d;
        default:   next_d = state_q;
      endcase
    end
  end

  // Translate the selected next value into per-bit J/K excitations:
  // set bits that must rise, clear bits that must fall, hold the rest.
  assign cell_j = next_d & ~state_q;
  assign cell_k = ~next_d & state_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j     (cell_j[gi]),
        .k     (cell_k[gi]),
        .q     (state_q[gi])
      );
    end
  endgenerate

  assign q  = state_q;
  assign qn = ~state_q;

  // Terminal count flags the value that the next enabled count would wrap.
  assign tc = en && (((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_zero));

`ifdef JK_MODE_COUNTER_WRAP_EN
  logic wrap_q;
  logic wrap_d;

  // A wrap happens when a count step is taken while the terminal flag is up.
  assign wrap_d = count_active && tc;

  // One-cycle pulse registered on the same edge that wraps q.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  // Without the wrap output, count_active has no consumer.
  logic unused_count_active;
  assign unused_count_active = count_active;
`endif

endmodule

// File: tb/tb_jk_mode_counter.sv
// Self-checking bench for jk_mode_counter (WIDTH=4, MAX_COUNT=9): directed
// scenarios plus randomized traffic against an arithmetic reference model.
module tb_jk_mode_counter;

  localparam int W    = 4;
  localparam int MAXC = 9;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         preset;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;
`ifdef JK_MODE_COUNTER_WRAP_EN
  logic         wrap;
`endif

  int model_q;
  int checks;
  int passed;

  jk_mode_counter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .preset   (preset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .j        (j),
    .k        (k),
    .q        (q),
    .qn       (qn),
    .tc       (tc)
`ifdef JK_MODE_COUNTER_WRAP_EN
    ,
    .wrap     (wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next state, written directly from the behavioural rules.
  function automatic int model_next(int m, bit rst, bit clr, bit pre, bit ld, int lv,
                                    bit e, int md, int jj, int kk);
    int r;
    if (rst) return 0;
    if (clr) return 0;
    if (pre) return MAXC;
    if (ld) return (lv > MAXC) ? MAXC : lv;
    if (!e) return m;
    case (md)
      1: return (m >= MAXC) ? 0 : m + 1;
      2: return (m == 0) ? MAXC : m - 1;
      3: begin
        r = 0;
        for (int b = 0; b < W; b++) begin
          int jb, kb, mb, nb;
          jb = (jj >> b) & 1;
          kb = (kk >> b) & 1;
          mb = (m >> b) & 1;
          if (jb == 1 && kb == 1) nb = 1 - mb;
          else if (jb == 1) nb = 1;
          else if (kb == 1) nb = 0;
          else nb = mb;
          r = r + (nb << b);
        end
        return r;
      end
      default: return m;
    endcase
  endfunction

  function automatic bit model_tc(int m, bit e, int md);
    return e && ((md == 1 && m >= MAXC) || (md == 2 && m == 0));
  endfunction

  // Advance one clock with the currently driven inputs and update the model.
  task automatic tick();
    int nxt;
    nxt = model_next(model_q, reset, clear, preset, load, int'(load_val), en,
                     int'(mode), int'(j), int'(k));
    @(posedge clk);
    model_q = nxt;
    #1;
    $display("txn t=%0t rst=%0b clr=%0b pre=%0b ld=%0b lv=%0d en=%0b mode=%0d j=%b k=%b -> q=%0d tc=%0b",
             $time, reset, clear, preset, load, load_val, en, mode, j, k, q, tc);
  endtask

  task automatic idle_inputs();
    reset = 0; clear = 0; preset = 0; load = 0; load_val = '0;
    en = 0; mode = 2'b00; j = '0; k = '0;
  endtask

  task automatic test_reset();
    reset = 1; clear = 0; preset = 1; load = 1; load_val = 4'd7;
    en = 1; mode = 2'b01; j = 4'hF; k = 4'h0;
    tick();
    checks++; if (q !== 4'd0) $display("FAIL reset_q got %0d expected 0", q); else passed++;
    checks++; if (qn !== 4'hF) $display("FAIL reset_qn got %h expected f", qn); else passed++;
    checks++; if (tc !== 1'b0) $display("FAIL reset_tc got %b expected 0", tc); else passed++;
    idle_inputs();
    #1;
  endtask

  task automatic test_count_up();
    en = 1; mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (tc !== ((i % 10) == 9)) $display("FAIL up_tc step %0d got %b expected %b", i, tc, (i % 10) == 9);
      else passed++;
      tick();
      checks++;
      if (q !== 4'((i + 1) % 10)) $display("FAIL up_q step %0d got %0d expected %0d", i, q, (i + 1) % 10);
      else passed++;
      checks++;
      if (qn !== ~q) $display("FAIL up_qn step %0d got %h expected %h", i, qn, ~q);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_load_down();
    load = 1; load_val = 4'd15; en = 1; mode = 2'b01;
    tick();
    checks++; if (q !== 4'd9) $display("FAIL load_clamp got %0d expected 9", q); else passed++;
    load = 0; mode = 2'b10;
    for (int i = 0; i < 11; i++) begin
      #1;
      checks++;
      if (tc !== (i == 9)) $display("FAIL down_tc step %0d got %b expected %b", i, tc, i == 9);
      else passed++;
      tick();
      checks++;
      if (q !== 4'((18 - i) % 10)) $display("FAIL down_q step %0d got %0d expected %0d", i, q, (18 - i) % 10);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_jk();
    load = 1; load_val = 4'b0101;
    tick();
    checks++; if (q !== 4'b0101) $display("FAIL jk_setup got %b expected 0101", q); else passed++;
    load = 0; en = 1; mode = 2'b11; j = 4'b1100; k = 4'b0110;
    #1;
    checks++; if (tc !== 1'b0) $display("FAIL jk_tc got %b expected 0", tc); else passed++;
    tick();
    checks++; if (q !== 4'b1001) $display("FAIL jk_q got %b expected 1001", q); else passed++;
    j = 4'b1111; k = 4'b0000;
    tick();
    checks++; if (q !== 4'd15) $display("FAIL jk_above_max got %0d expected 15", q); else passed++;
    j = '0; mode = 2'b01;
    #1;
    checks++; if (tc !== 1'b1) $display("FAIL above_max_tc got %b expected 1", tc); else passed++;
    tick();
    checks++; if (q !== 4'd0) $display("FAIL above_max_wrap got %0d expected 0", q); else passed++;
    idle_inputs();
  endtask

  task automatic test_clear_preset();
    load = 1; load_val = 4'd5;
    tick();
    clear = 1; preset = 1; load = 1; load_val = 4'd3;
    tick();
    checks++; if (q !== 4'd0) $display("FAIL clear_wins got %0d expected 0", q); else passed++;
    clear = 0; load = 0;
    tick();
    checks++; if (q !== 4'd9) $display("FAIL preset got %0d expected 9", q); else passed++;
    preset = 0; reset = 1; en = 1; mode = 2'b01;
    tick();
    checks++; if (q !== 4'd0) $display("FAIL reset_midcount got %0d expected 0", q); else passed++;
    reset = 0;
    tick();
    checks++; if (q !== 4'd1) $display("FAIL resume_after_reset got %0d expected 1", q); else passed++;
    idle_inputs();
  endtask

  task automatic test_enable_hold();
    load = 1; load_val = 4'd6;
    tick();
    load = 0; en = 0; mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (tc !== 1'b0) $display("FAIL hold_tc step %0d got %b expected 0", i, tc); else passed++;
      tick();
      checks++; if (q !== 4'd6) $display("FAIL hold_q step %0d got %0d expected 6", i, q); else passed++;
      checks++; if (qn !== 4'd9) $display("FAIL hold_qn step %0d got %h expected 9", i, qn); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset    = ($urandom_range(0, 24) == 0);
      clear    = ($urandom_range(0, 14) == 0);
      preset   = ($urandom_range(0, 14) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      j        = W'($urandom_range(0, 15));
      k        = W'($urandom_range(0, 15));
      #1;
      checks++;
      if (tc !== model_tc(model_q, en, int'(mode)))
        $display("FAIL rand_tc iter %0d got %b expected %b", i, tc, model_tc(model_q, en, int'(mode)));
      else passed++;
      tick();
      checks++;
      if (q !== W'(model_q)) $display("FAIL rand_q iter %0d got %0d expected %0d", i, q, model_q);
      else passed++;
      checks++;
      if (qn !== ~W'(model_q)) $display("FAIL rand_qn iter %0d got %h expected %h", i, qn, ~W'(model_q));
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    model_q = 0;
    idle_inputs();
    test_reset();
    test_count_up();
    test_load_down();
    test_jk();
    test_clear_preset();
    test_enable_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
